// File: rtl/multicycle_pkg.sv
// Shared state encoding, opcodes and datapath select codes for the multicycle controller.
package multicycle_pkg;

    typedef enum logic [3:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC_R,
        WB_R,
        EXEC_I,
        WB_I,
        ADDR,
        MEM_RD,
        MEM_WR,
        BRANCH,
        JAL,
        JR,
        HALT,
        FAULT
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_ADDI = 4'h4;
    localparam logic [3:0] OP_LW   = 4'h5;
    localparam logic [3:0] OP_SW   = 4'h6;
    localparam logic [3:0] OP_BEQ  = 4'h7;
    localparam logic [3:0] OP_JAL  = 4'h8;
    localparam logic [3:0] OP_JR   = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [1:0] M2R_ALU = 2'b00;
    localparam logic [1:0] M2R_MEM = 2'b01;
    localparam logic [1:0] M2R_PC  = 2'b10;

    localparam logic [1:0] R1_IR11_8 = 2'b00;
    localparam logic [1:0] R1_IR7_4  = 2'b01;
    localparam logic [1:0] R1_IR3_0  = 2'b10;
    localparam logic [1:0] R1_R15    = 2'b11;

    localparam logic [1:0] RWC_IR11_8 = 2'b00;
    localparam logic [1:0] RWC_IR7_4  = 2'b01;
    localparam logic [1:0] RWC_IR3_0  = 2'b10;
    localparam logic [1:0] RWC_R15    = 2'b11;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_ONE   = 2'b01;
    localparam logic [1:0] SRCB_SEXT4 = 2'b10;
    localparam logic [1:0] SRCB_SEXT8 = 2'b11;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;
    localparam logic [1:0] PCS_READ1  = 2'b11;

    function automatic logic is_mem_state(input state_t s);
        return (s == FETCH) || (s == MEM_RD) || (s == MEM_WR);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive stalled cycles of a memory request; flags a timeout when the
// limit is reached and the request is still not ready.
module mem_wait_timer #(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_active,
    input  logic i_ready,
    output logic o_timeout
);

    localparam int CW = (MEM_WAIT_MAX < 1) ? 1 : $clog2(MEM_WAIT_MAX + 1);

    logic [CW-1:0] r_count;
    logic          w_at_max;

    assign w_at_max  = (r_count == CW'(MEM_WAIT_MAX));
    assign o_timeout = i_active && !i_ready && w_at_max;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (!i_active || i_ready) begin
            r_count <= '0;
        end else if (!w_at_max) begin
            r_count <= r_count + CW'(1);
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle control FSM: fetch/decode/execute/memory/writeback sequencing for the
// 16-bit, 4-bit-opcode ISA, with memory-stall timeout and illegal-opcode fault.
module multicycle_control
    import multicycle_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic       Clock,
    input  logic       Reset_n,
    input  logic [3:0] IR15_12,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] MemToReg,
    output logic [1:0] RegOneRead,
    output logic       RegTwoRead,
    output logic [1:0] RegWriteCode,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IorD,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic [1:0] PCSource,
    output logic       Halted,
    output logic       Fault
);

    state_t r_state;
    state_t w_state_next;
    logic   w_mem_active;
    logic   w_timeout;
    logic   w_unused;

    // Zero qualifies PCWriteCond in the datapath; the sequencer itself never needs it.
    assign w_unused     = Zero;
    assign w_mem_active = is_mem_state(r_state);

    mem_wait_timer #(
        .MEM_WAIT_MAX(MEM_WAIT_MAX)
    ) u_mem_wait_timer (
        .i_clk    (Clock),
        .i_rst_n  (Reset_n),
        .i_active (w_mem_active),
        .i_ready  (MemReady),
        .o_timeout(w_timeout)
    );

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        IRWrite      = 1'b0;
        RegWrite     = 1'b0;
        MemToReg     = M2R_ALU;
        RegOneRead   = R1_IR11_8;
        RegTwoRead   = 1'b0;
        RegWriteCode = RWC_IR11_8;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        IorD         = 1'b0;
        ALUSrcA      = 1'b0;
        ALUSrcB      = SRCB_REG;
        ALUOp        = ALU_ADD;
        PCWrite      = 1'b0;
        PCWriteCond  = 1'b0;
        PCSource     = PCS_ALU;
        Halted       = 1'b0;
        Fault        = 1'b0;

        case (r_state)
            IDLE: w_state_next = FETCH;
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_ONE;
                if (MemReady) begin
                    IRWrite      = 1'b1;
                    PCWrite      = 1'b1;
                    w_state_next = DECODE;
                end else if (w_timeout) begin
                    w_state_next = FAULT;
                end
            end
            DECODE: begin
                ALUSrcB = SRCB_SEXT4;
                case (IR15_12)
                    OP_ADD, OP_SUB, OP_AND, OP_OR: w_state_next = EXEC_R;
                    OP_ADDI:                       w_state_next = EXEC_I;
                    OP_LW, OP_SW:                  w_state_next = ADDR;
                    OP_BEQ:                        w_state_next = BRANCH;
                    OP_JAL:                        w_state_next = JAL;
                    OP_JR:                         w_state_next = JR;
                    OP_HALT:                       w_state_next = HALT;
                    default:                       w_state_next = FAULT;
                endcase
            end
            EXEC_R: begin
                RegOneRead   = R1_IR7_4;
                RegTwoRead   = 1'b1;
                ALUSrcA      = 1'b1;
                ALUOp        = IR15_12[1:0];
                w_state_next = WB_R;
            end
            WB_R, WB_I: begin
                RegWrite     = 1'b1;
                w_state_next = FETCH;
            end
            EXEC_I: begin
                ALUSrcA      = 1'b1;
                ALUSrcB      = SRCB_SEXT8;
                w_state_next = WB_I;
            end
            ADDR: begin
                RegOneRead   = R1_IR7_4;
                ALUSrcA      = 1'b1;
                ALUSrcB      = SRCB_SEXT4;
                w_state_next = (IR15_12 == OP_SW) ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
                MemRead  = 1'b1;
                IorD     = 1'b1;
                MemToReg = M2R_MEM;
                if (MemReady) begin
                    RegWrite     = 1'b1;
                    w_state_next = FETCH;
                end else if (w_timeout) begin
                    w_state_next = FAULT;
                end
            end
            MEM_WR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (MemReady) begin
                    w_state_next = FETCH;
                end else if (w_timeout) begin
                    w_state_next = FAULT;
                end
            end
            BRANCH: begin
                ALUSrcA      = 1'b1;
                ALUOp        = ALU_SUB;
                PCWriteCond  = 1'b1;
                PCSource     = PCS_ALUOUT;
                w_state_next = FETCH;
            end
            // r15 captures the already-incremented PC on the same edge the jump loads.
            JAL: begin
                RegWrite     = 1'b1;
                MemToReg     = M2R_PC;
                RegWriteCode = RWC_R15;
                PCWrite      = 1'b1;
                PCSource     = PCS_JUMP;
                w_state_next = FETCH;
            end
            JR: begin
                PCWrite      = 1'b1;
                PCSource     = PCS_READ1;
                w_state_next = FETCH;
            end
            HALT:    Halted = 1'b1;
            FAULT:   Fault  = 1'b1;
            default: w_state_next = FAULT;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed checks of the multicycle controller sequencing, gating and fault paths.
module tb_multicycle_control;

    logic       Clock = 1'b0;
    logic       Reset_n = 1'b1;
    logic [3:0] IR15_12 = 4'h0;
    logic       Zero = 1'b0;
    logic       MemReady = 1'b0;
    logic       IRWrite, RegWrite, RegTwoRead, MemRead, MemWrite, IorD, ALUSrcA;
    logic       PCWrite, PCWriteCond, Halted, Fault;
    logic [1:0] MemToReg, RegOneRead, RegWriteCode, ALUSrcB, ALUOp, PCSource;
    logic [22:0] w_all;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 Clock = ~Clock;

    multicycle_control #(.MEM_WAIT_MAX(15)) dut (
        .Clock       (Clock),
        .Reset_n     (Reset_n),
        .IR15_12     (IR15_12),
        .Zero        (Zero),
        .MemReady    (MemReady),
        .IRWrite     (IRWrite),
        .RegWrite    (RegWrite),
        .MemToReg    (MemToReg),
        .RegOneRead  (RegOneRead),
        .RegTwoRead  (RegTwoRead),
        .RegWriteCode(RegWriteCode),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IorD        (IorD),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ALUOp       (ALUOp),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .PCSource    (PCSource),
        .Halted      (Halted),
        .Fault       (Fault)
    );

    assign w_all = {IRWrite, RegWrite, MemToReg, RegOneRead, RegTwoRead, RegWriteCode,
                    MemRead, MemWrite, IorD, ALUSrcA, ALUSrcB, ALUOp, PCWrite,
                    PCWriteCond, PCSource, Halted, Fault};

    task automatic chk(input string tag, input logic [22:0] obs, input logic [22:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Leaves the DUT in FETCH, one cycle after reset release.
    task automatic do_reset(input string tag);
        Reset_n = 1'b0;
        #1 chk({tag, "_async_zero"}, w_all, 23'd0);
        @(negedge Clock);
        Reset_n = 1'b1;
        #1 chk({tag, "_idle_zero"}, w_all, 23'd0);
        tick();
        chk({tag, "_fetch"}, {MemRead, IorD, ALUSrcA, ALUSrcB, ALUOp, IRWrite, PCWrite},
            {1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0});
    endtask

    // Completes the current FETCH and leaves the DUT in DECODE with the opcode applied.
    task automatic fetch_ok(input string tag, input logic [3:0] op);
        MemReady = 1'b1;
        #1 chk({tag, "_fetch_ready"}, {IRWrite, PCWrite, MemRead}, 3'b111);
        tick();
        MemReady = 1'b0;
        IR15_12  = op;
        #1;
    endtask

    initial begin
        #1;
        do_reset("por");

        // ADD
        fetch_ok("add", 4'h0);
        chk("add_decode", {ALUSrcA, ALUSrcB, ALUOp, RegOneRead, RegTwoRead, IRWrite, MemRead},
            {1'b0, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0});
        tick();
        chk("add_exec", {RegOneRead, RegTwoRead, ALUSrcA, ALUSrcB, ALUOp, RegWrite},
            {2'b01, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0});
        tick();
        chk("add_wb", {RegWrite, MemToReg, RegWriteCode, MemRead}, {1'b1, 2'b00, 2'b00, 1'b0});
        tick();
        chk("add_next_fetch", {MemRead, IorD, RegWrite}, 3'b100);

        // OR: ALUOp follows opcode low bits
        fetch_ok("or", 4'h3);
        tick();
        chk("or_exec_aluop", {ALUOp, ALUSrcA}, {2'b11, 1'b1});
        tick();
        chk("or_wb", {RegWrite, MemToReg}, {1'b1, 2'b00});
        tick();

        // ADDI
        fetch_ok("addi", 4'h4);
        tick();
        chk("addi_exec", {ALUSrcA, ALUSrcB, RegOneRead, ALUOp}, {1'b1, 2'b11, 2'b00, 2'b00});
        tick();
        chk("addi_wb", {RegWrite, MemToReg, RegWriteCode}, {1'b1, 2'b00, 2'b00});
        tick();

        // LW with MemReady delayed 3 cycles
        fetch_ok("lw", 4'h5);
        tick();
        chk("lw_addr", {RegOneRead, ALUSrcA, ALUSrcB, ALUOp, MemRead},
            {2'b01, 1'b1, 2'b10, 2'b00, 1'b0});
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("lw_wait", {MemRead, IorD, RegWrite, MemWrite, Fault}, 5'b11000);
            tick();
        end
        MemReady = 1'b1;
        #1 chk("lw_done", {MemRead, IorD, RegWrite, MemToReg, RegWriteCode},
               {1'b1, 1'b1, 1'b1, 2'b01, 2'b00});
        tick();
        MemReady = 1'b0;
        #1 chk("lw_next_fetch", {MemRead, IorD, RegWrite}, 3'b100);

        // SW
        fetch_ok("sw", 4'h6);
        tick();
        tick();
        chk("sw_mem", {MemWrite, MemRead, IorD, RegTwoRead, RegWrite}, 5'b10100);
        MemReady = 1'b1;
        #1 tick();
        MemReady = 1'b0;
        #1 chk("sw_next_fetch", {MemRead, MemWrite}, 2'b10);

        // BEQ
        fetch_ok("beq", 4'h7);
        tick();
        chk("beq", {PCWriteCond, PCSource, ALUOp, ALUSrcA, ALUSrcB, RegOneRead, PCWrite},
            {1'b1, 2'b01, 2'b01, 1'b1, 2'b00, 2'b00, 1'b0});
        tick();
        chk("beq_done", {PCWriteCond, MemRead}, 2'b01);

        // JAL
        fetch_ok("jal", 4'h8);
        tick();
        chk("jal", {RegWrite, MemToReg, RegWriteCode, PCWrite, PCSource},
            {1'b1, 2'b10, 2'b11, 1'b1, 2'b10});
        tick();
        chk("jal_done", {MemRead, RegWrite, PCWrite}, 3'b100);

        // JR
        fetch_ok("jr", 4'h9);
        tick();
        chk("jr", {PCWrite, PCSource, RegOneRead, RegWrite}, {1'b1, 2'b11, 2'b00, 1'b0});
        tick();

        // Reset in the middle of MEM_RD
        fetch_ok("lw2", 4'h5);
        tick();
        tick();
        chk("lw2_memrd", {MemRead, IorD}, 2'b11);
        do_reset("midrd");

        // MemReady on the cycle the limit is reached completes the fetch
        for (int i = 0; i < 15; i++) begin
            chk("wait_no_fault", {Fault, MemRead, IRWrite}, 3'b010);
            tick();
        end
        MemReady = 1'b1;
        #1 chk("ready_at_limit", {IRWrite, PCWrite, Fault}, 3'b110);
        tick();
        MemReady = 1'b0;
        IR15_12  = 4'hB;
        #1 chk("decode_after_limit", {ALUSrcB, Fault, MemRead}, {2'b10, 1'b0, 1'b0});
        tick();
        chk("illegal_fault", {Fault, Halted, MemRead}, 3'b100);
        MemReady = 1'b1;
        tick();
        tick();
        chk("fault_held", {Fault, Halted, MemRead, IRWrite}, 4'b1000);
        MemReady = 1'b0;

        // Fetch timeout after 16 stalled cycles
        do_reset("to");
        for (int i = 0; i < 15; i++) tick();
        chk("timeout_pre", {Fault, MemRead}, 2'b01);
        tick();
        chk("timeout_fault", {Fault, MemRead, IRWrite}, 3'b100);

        // HALT
        do_reset("halt");
        fetch_ok("halt", 4'hF);
        tick();
        chk("halted", {Halted, MemRead, Fault}, 3'b100);
        MemReady = 1'b1;
        tick();
        tick();
        tick();
        chk("halt_held", {Halted, MemRead, IRWrite, PCWrite}, 4'b1000);
        MemReady = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
